uart_rx_oversample: RTL and testbench

- 16x-oversampled UART receive front-end feeding the transmit/echo path of the UART block.
- Synchronises the asynchronous serial line, detects and validates start bits, majority-samples 8N1 frames, and presents each byte on a valid/ready interface backed by a one-entry holding register.
- Flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_oversample_if.sv | 8 +
 rtl/uart_baud_tick.sv | 15 +
 rtl/uart_rx_oversample.sv | 104 ++++++++++
 tb/tb_uart_rx_oversample.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default rates, divider helper and oversample tick positions
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  localparam int DEF_CLK_HZ = 12000000;
  localparam int DEF_BAUD = 9600;
  localparam int DEF_OVS = 16;
  localparam int SAMPLE_MID = 8;
  localparam int START_CHECK = 7;
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction
endpackage

// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if: received-byte valid/ready channel
interface uart_rx_oversample_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..DIV-1 divider with sync clear, one-cycle tick at DIV-1
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    cnt <= (!nrst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampled 8N1 receiver with holding register; UART_RX_PARITY_EN adds even parity
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD = DEF_BAUD,
  parameter int OVS = DEF_OVS
) (
  input  logic clk,
  input  logic nrst,
  input  logic rx_i,
  uart_rx_oversample_if.master rx,
  output logic frame_err,
  output logic parity_err,
  output logic overrun,
  output logic busy,
  output logic idle
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int TW = $clog2(OVS);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic pbit;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, nxt;
  logic [1:0] sync;
  logic rxs, tick, leave, at_chk, at_mid, at_end, at_smp, maj;
  logic stop_dec, par_bad, ferr, deliver;
  logic [TW-1:0] tk;
  logic [2:0] idx;
  logic [1:0] smp;
  logic [7:0] sh;
  assign rxs = sync[1];
  assign leave = state == IDLE && nxt != IDLE;
  assign at_chk = tick && tk == TW'(START_CHECK);
  assign at_mid = tick && tk == TW'(SAMPLE_MID);
  assign at_end = tick && tk == TW'(OVS - 1);
  assign at_smp = tick && (tk == TW'(SAMPLE_MID - 2) || tk == TW'(SAMPLE_MID - 1));
  assign maj = (smp[1] & smp[0]) | (smp[1] & rxs) | (smp[0] & rxs);
  // clearing the divider on the start edge phase-aligns every sample to the falling edge
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .nrst (nrst),
    .clr  (leave),
    .tick (tick)
  );
  always_ff @(posedge clk)
    state <= nrst ? nxt : IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rxs ? IDLE : START;
      START:   nxt = (at_chk && rxs) ? IDLE : at_end ? DATA : START;
      DATA:    nxt = (at_end && idx == 3'd7) ? AFTER_DATA : DATA;
      PARITY:  nxt = at_end ? STOP : PARITY;
      STOP:    nxt = at_mid ? (maj ? IDLE : BRK) : STOP;
      BRK:     nxt = rxs ? IDLE : BRK;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    stop_dec = state == STOP && at_mid;
`ifdef UART_RX_PARITY_EN
    par_bad = stop_dec && (^sh ^ pbit);
`else
    par_bad = 1'b0;
`endif
    ferr = stop_dec && !maj;
    deliver = stop_dec && maj && !par_bad;
    busy = state != IDLE;
    idle = state == IDLE;
  end
  always_ff @(posedge clk)
    if (!nrst) begin
      sync <= 2'b11;
      tk <= '0;
      idx <= '0;
      smp <= '0;
      sh <= '0;
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx_i};
      tk <= (leave || at_end) ? '0 : tk + TW'(tick);
      idx <= state == START ? '0 : idx + 3'(state == DATA && at_end);
      smp <= at_smp ? {smp[0], rxs} : smp;
      sh <= (state == DATA && at_mid) ? {maj, sh[7:1]} : sh;
      frame_err <= ferr;
      parity_err <= par_bad;
      // a full, unaccepted holding register keeps the old byte and drops the new one
      rx.rx_data <= (deliver && !(rx.rx_valid && !rx.rx_ready)) ? sh : rx.rx_data;
      rx.rx_valid <= deliver || (rx.rx_valid && !rx.rx_ready);
      overrun <= overrun || (deliver && rx.rx_valid && !rx.rx_ready);
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk)
    pbit <= !nrst ? 1'b0 : (state == PARITY && at_mid) ? maj : pbit;
`endif
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: frame-level event model with timing windows plus literal spot checks
module tb_uart_rx_oversample;
  localparam int CLK_HZ = 307200;
  localparam int BAUD = 9600;
  localparam int OVS = 16;
  localparam int BIT = CLK_HZ / (BAUD * OVS) * OVS;
  localparam int WIN = 12;
`ifdef UART_RX_PARITY_EN
  localparam int DEC = BIT * 21 / 2;
`else
  localparam int DEC = BIT * 19 / 2;
`endif
  typedef enum {DELIV, OVR, FERR, PERR} kind_t;
  typedef struct {kind_t k; logic [7:0] d; int t;} ev_t;
  typedef struct {string n; logic [31:0] a; logic [31:0] e;} lit_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic rx_i = 1'b1;
  logic frame_err, parity_err, overrun, busy, idle;
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  ev_t q[$];
  lit_t lq[$];
  logic held = 1'b0;
  logic ovr_m = 1'b0;
  uart_rx_oversample_if bus ();
  uart_rx_oversample #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx_i       (rx_i),
    .rx         (bus),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy),
    .idle       (idle)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic pv = 1'b0, pacc = 1'b0, povr = 1'b0, prst = 1'b1;
  logic [7:0] pdata = '0, last_data = '0;
  int n_deliv = 0, n_ferr = 0, n_perr = 0, li = 0, qi = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  task automatic match(input kind_t k, input logic [7:0] d);
    vecs++;
    if (qi >= q.size()) begin
      errs++;
      $display("FAIL unexpected_%s: got 0x%02h at cycle %0d, want no event", k.name(), d, cyc);
    end else begin
      if (q[qi].k != k || (k == DELIV && q[qi].d != d) || cyc < q[qi].t - WIN || cyc > q[qi].t + WIN) begin
        errs++;
        $display("FAIL event: got %s 0x%02h at cycle %0d, want %s 0x%02h at cycle %0d", k.name(), d, cyc,
                 q[qi].k.name(), q[qi].d, q[qi].t);
      end
      qi++;
    end
  endtask
  always @(negedge clk) begin
    while (li < lq.size()) begin
      chk(lq[li].n, lq[li].a, lq[li].e);
      li++;
    end
    chk("idle_is_not_busy", idle, !busy);
`ifndef UART_RX_PARITY_EN
    chk("parity_err_tied", parity_err, 1'b0);
`endif
    if (prst) begin
      chk("rst_valid", bus.rx_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end else begin
      if (pv && !pacc) chk("held_data", bus.rx_data, pdata);
      if (povr) chk("overrun_sticky", overrun, 1'b1);
      if (bus.rx_valid && (!pv || pacc)) begin
        match(DELIV, bus.rx_data);
        last_data = bus.rx_data;
        n_deliv++;
      end
      if (frame_err) begin
        match(FERR, 8'h00);
        n_ferr++;
      end
      if (parity_err) begin
        match(PERR, 8'h00);
        n_perr++;
      end
      if (overrun && !povr) match(OVR, 8'h00);
      if (qi < q.size() && cyc > q[qi].t + WIN) begin
        vecs++;
        errs++;
        $display("FAIL missing_event: got nothing by cycle %0d, want %s 0x%02h at cycle %0d", cyc,
                 q[qi].k.name(), q[qi].d, q[qi].t);
        qi++;
      end
    end
    pv = bus.rx_valid;
    pacc = bus.rx_valid && bus.rx_ready;
    pdata = bus.rx_data;
    povr = overrun;
    prst = !nrst;
  end
  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    lq.push_back('{n, a, e});
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_ready(input logic v);
    bus.rx_ready = v;
    if (v) held = 1'b0;
  endtask
  task automatic expect_frame(input logic [7:0] d, input logic stop, input logic pbad, input int t);
    if (!stop) q.push_back('{FERR, d, t});
    else if (pbad) q.push_back('{PERR, d, t});
    else if (held && !bus.rx_ready) begin
      if (!ovr_m) q.push_back('{OVR, d, t});
      ovr_m = 1'b1;
    end else begin
      q.push_back('{DELIV, d, t});
      held = !bus.rx_ready;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int rst_bit, input logic pbad);
    logic [10:0] fr;
    int n;
    int t0;
`ifdef UART_RX_PARITY_EN
    fr = {stop, ^d ^ pbad, d, 1'b0};
    n = 11;
`else
    fr = {1'b0, stop, d, 1'b0};
    n = 10;
`endif
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      rx_i = fr[i];
      if (i == n - 1 && rst_bit < 0) expect_frame(d, stop, pbad, t0 + DEC);
      for (int j = 0; j < BIT; j++) begin
        if (i == rst_bit && j == BIT / 2) begin
          nrst = 1'b0;
          held = 1'b0;
          ovr_m = 1'b0;
        end
        step(1);
        nrst = 1'b1;
      end
    end
  endtask
  initial begin
    logic [7:0] four [4];
    int base;
    four = '{8'h53, 8'h6E, 8'h61, 8'h70};
    bus.rx_ready = 1'b0;
    step(3);
    lit("reset_rx_data", bus.rx_data, 8'h00);
    lit("reset_rx_valid", bus.rx_valid, 1'b0);
    lit("reset_frame_err", frame_err, 1'b0);
    lit("reset_overrun", overrun, 1'b0);
    lit("reset_idle", idle, 1'b1);
    nrst = 1'b1;
    step(2 * BIT);
    set_ready(1'b1);
    send(8'h53, 1'b1, -1, 1'b0);
    lit("first_byte", last_data, 8'h53);
    lit("first_count", n_deliv, 1);
    lit("first_idle", idle, 1'b1);
    lit("first_pulse_gone", bus.rx_valid, 1'b0);
    rx_i = 1'b0;
    step(3);
    rx_i = 1'b1;
    step(2);
    lit("glitch_busy", busy, 1'b1);
    step(BIT);
    lit("glitch_idle", idle, 1'b1);
    lit("glitch_no_valid", bus.rx_valid, 1'b0);
    lit("glitch_no_overrun", overrun, 1'b0);
    send(8'hA5, 1'b0, -1, 1'b0);
    step(3 * BIT);
    lit("brk_busy", busy, 1'b1);
    lit("ferr_no_valid", bus.rx_valid, 1'b0);
    lit("ferr_count", n_ferr, 1);
    rx_i = 1'b1;
    step(4);
    lit("brk_idle", idle, 1'b1);
    step(BIT);
    set_ready(1'b0);
    send(8'h6E, 1'b1, -1, 1'b0);
    send(8'h61, 1'b1, -1, 1'b0);
    step(2);
    lit("ovr_held_data", bus.rx_data, 8'h6E);
    lit("ovr_valid", bus.rx_valid, 1'b1);
    lit("ovr_flag", overrun, 1'b1);
    set_ready(1'b1);
    step(2);
    lit("ovr_accept_clears", bus.rx_valid, 1'b0);
    lit("ovr_still_set", overrun, 1'b1);
    base = n_deliv;
    foreach (four[i]) send(four[i], 1'b1, -1, 1'b0);
    lit("four_count", n_deliv - base, 4);
    lit("four_last", last_data, 8'h70);
    base = n_deliv;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1, -1, 1'b0);
      step(BIT * $urandom_range(1, 24));
    end
    lit("random_count", n_deliv - base, 60);
    base = n_deliv;
    send(8'hFF, 1'b1, 4, 1'b0);
    step(BIT);
    lit("abort_no_byte", n_deliv - base, 0);
    lit("abort_overrun_cleared", overrun, 1'b0);
    send(8'h70, 1'b1, -1, 1'b0);
    lit("post_abort_byte", last_data, 8'h70);
    lit("post_abort_count", n_deliv - base, 1);
`ifdef UART_RX_PARITY_EN
    base = n_deliv;
    send(8'h53, 1'b1, -1, 1'b1);
    lit("perr_count", n_perr, 1);
    lit("perr_no_byte", n_deliv - base, 0);
    lit("perr_no_valid", bus.rx_valid, 1'b0);
`endif
    step(2 * BIT);
    lit("all_events_seen", q.size() - qi, 0);
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
